// File: rtl/coh_ctrl_n.sv
// ---------------------------------------------------------------------------
// coh_ctrl_n : N-core snoopy MSI coherence controller and single-port RAM
// arbiter. All RAM traffic from CPUS I/D cache pairs is serialised here.
//
// Optional feature macro: COH_PERF_CNT_EN (builds perf_trans / perf_c2c
// counters; when undefined both outputs are constant 0).
//
// Ports
//   CLK, nRST                 clock, async active-low reset
//   iREN/iaddr -> iwait/iload instruction fetch per core
//   dREN/dWEN/daddr/dstore    data read / eviction write per core
//   -> dwait/dload
//   cctrans/ccwrite           coherence transaction / BusRdX-or-Modified flag
//   ccwait/ccinv/ccsnoopaddr  snoop request, invalidate and address per core
//   ramREN/ramWEN/ramaddr/    single RAM port, ramstate FREE=0 BUSY=1
//   ramstore/ramload/ramstate ACCESS=2 ERROR=3
//   perf_c2c/perf_trans       performance counters
//   dbg_state                 FSM state (IDLE=0 SNOOP=1 C2C_XFER=2 RAM_XFER=3)
//
// Handshake: a core holds its request (iREN, dWEN, or cctrans with dREN/dWEN)
// stable until its wait bit is 0; the wait bit is 0 for exactly the one cycle
// in which ramstate==ACCESS completes that word, and load data is valid in
// that same cycle. Any other ramstate (including ERROR) just stalls.
// ---------------------------------------------------------------------------
module coh_ctrl_n #(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*AW-1:0]   iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS*DW-1:0]   iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*AW-1:0]   daddr,
  input  logic [CPUS*DW-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*DW-1:0]   dload,
  input  logic [CPUS-1:0]      cctrans,
  input  logic [CPUS-1:0]      ccwrite,
  output logic [CPUS-1:0]      ccwait,
  output logic [CPUS-1:0]      ccinv,
  output logic [CPUS*AW-1:0]   ccsnoopaddr,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [AW-1:0]        ramaddr,
  output logic [DW-1:0]        ramstore,
  input  logic [DW-1:0]        ramload,
  input  logic [1:0]           ramstate,
  output logic [31:0]          perf_c2c,
  output logic [31:0]          perf_trans,
  output logic [1:0]           dbg_state
);

  localparam int CW  = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CW1 = CW + 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, SNOOP, C2C_XFER, RAM_XFER} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   req, req_n, sup, sup_n;
  logic [CW-1:0]   dptr, dptr_n, iptr, iptr_n;
  logic [CW-1:0]   w;
  logic            trans_inc, c2c_inc, snoop_on, access;
  logic [CPUS-1:0] others, evict;

  logic [AW-1:0] iaddr_a  [CPUS];
  logic [AW-1:0] daddr_a  [CPUS];
  logic [DW-1:0] dstore_a [CPUS];
  logic [DW-1:0] iload_a  [CPUS];
  logic [DW-1:0] dload_a  [CPUS];

  // Lowest-index set bit of mask at or after ptr, wrapping at CPUS.
  function automatic logic [CW-1:0] rr_pick(input logic [CPUS-1:0] mask,
                                            input logic [CW-1:0] ptr);
    logic [CW-1:0] res;
    logic          found;
    logic [CW1-1:0] j;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      j = {1'b0, ptr} + CW1'(i);
      if (j >= CW1'(CPUS)) j = j - CW1'(CPUS);
      if (!found && mask[j[CW-1:0]]) begin
        found = 1'b1;
        res   = j[CW-1:0];
      end
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] nxt(input logic [CW-1:0] p);
    return (int'(p) == CPUS - 1) ? '0 : p + CW'(1);
  endfunction

  for (genvar g = 0; g < CPUS; g++) begin : g_pack
    assign iaddr_a[g]  = iaddr[g*AW +: AW];
    assign daddr_a[g]  = daddr[g*AW +: AW];
    assign dstore_a[g] = dstore[g*DW +: DW];
    assign iload[g*DW +: DW] = iload_a[g];
    assign dload[g*DW +: DW] = dload_a[g];
    assign ccsnoopaddr[g*AW +: AW] = (snoop_on && others[g]) ? daddr_a[req] : '0;
  end

  assign others    = ~(CPUS'(1) << req);
  assign evict     = dWEN & ~cctrans;
  assign access    = (ramstate == RAM_ACCESS);
  assign dbg_state = state;

  // Outputs are forced to their idle values while nRST is low so that an
  // asserted reset is visible immediately, whatever the cores are driving.
  always_comb begin
    iwait     = '1;
    dwait     = '1;
    ccwait    = '0;
    ccinv     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iload_a   = '{default: '0};
    dload_a   = '{default: '0};
    snoop_on  = 1'b0;
    w         = '0;
    state_n   = state;
    req_n     = req;
    sup_n     = sup;
    dptr_n    = dptr;
    iptr_n    = iptr;
    trans_inc = 1'b0;
    c2c_inc   = 1'b0;
    if (nRST) begin
      case (state)
        IDLE: begin
          if (|evict) begin
            w        = rr_pick(evict, dptr);
            ramWEN   = 1'b1;
            ramaddr  = daddr_a[w];
            ramstore = dstore_a[w];
            if (access) begin
              dwait[w] = 1'b0;
              dptr_n   = nxt(w);
            end
          end else if (|cctrans) begin
            // Only latch the requester; the bus is not touched this cycle.
            w         = rr_pick(cctrans, dptr);
            req_n     = w;
            state_n   = SNOOP;
            trans_inc = 1'b1;
          end else if (|iREN) begin
            w       = rr_pick(iREN, iptr);
            ramREN  = 1'b1;
            ramaddr = iaddr_a[w];
            if (access) begin
              iwait[w]   = 1'b0;
              iload_a[w] = ramload;
              iptr_n     = nxt(w);
            end
          end
        end
        SNOOP: begin
          if (!cctrans[req]) begin
            state_n = IDLE;
          end else begin
            snoop_on = 1'b1;
            if (|(ccwrite & others)) begin
              // A Modified holder supplies the line; lowest index wins.
              sup_n   = rr_pick(ccwrite & others, '0);
              state_n = C2C_XFER;
              c2c_inc = 1'b1;
            end else begin
              state_n = RAM_XFER;
            end
          end
        end
        C2C_XFER: begin
          if (!cctrans[req]) begin
            state_n = IDLE;
            dptr_n  = nxt(req);
          end else begin
            snoop_on     = 1'b1;
            dload_a[req] = dstore_a[sup];
            ramWEN       = 1'b1;
            ramaddr      = daddr_a[req];
            ramstore     = dstore_a[sup];
            if (access) begin
              dwait[req] = 1'b0;
              dwait[sup] = 1'b0;
            end
          end
        end
        RAM_XFER: begin
          if (!cctrans[req]) begin
            state_n = IDLE;
            dptr_n  = nxt(req);
          end else begin
            snoop_on     = 1'b1;
            ramREN       = dREN[req];
            ramWEN       = dWEN[req];
            ramaddr      = daddr_a[req];
            ramstore     = dstore_a[req];
            dload_a[req] = ramload;
            if (access) dwait[req] = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
      if (snoop_on) begin
        ccwait = others;
        ccinv  = ccwrite[req] ? others : '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      req   <= '0;
      sup   <= '0;
      dptr  <= '0;
      iptr  <= '0;
    end else begin
      state <= state_n;
      req   <= req_n;
      sup   <= sup_n;
      dptr  <= dptr_n;
      iptr  <= iptr_n;
    end
  end

`ifdef COH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_trans <= '0;
      perf_c2c   <= '0;
    end else begin
      if (trans_inc) perf_trans <= perf_trans + 32'd1;
      if (c2c_inc)   perf_c2c   <= perf_c2c + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = trans_inc ^ c2c_inc;
  assign perf_trans  = '0;
  assign perf_c2c    = '0;
`endif

endmodule

// File: tb/tb_coh_ctrl_n.sv
module tb_coh_ctrl_n;

  localparam int N = 4;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;
`ifdef COH_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          CLK, nRST;
  logic [N-1:0]  iREN, dREN, dWEN, cctrans, ccwrite;
  logic [N*32-1:0] iaddr, daddr, dstore;
  logic [N-1:0]  iwait, dwait, ccwait, ccinv;
  logic [N*32-1:0] iload, dload, ccsnoopaddr;
  logic          ramREN, ramWEN;
  logic [31:0]   ramaddr, ramstore, ramload;
  logic [1:0]    ramstate;
  logic [31:0]   perf_c2c, perf_trans;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  coh_ctrl_n #(.CPUS(N), .AW(32), .DW(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .perf_c2c(perf_c2c), .perf_trans(perf_trans), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] wd(input logic [N*32-1:0] v, input int k);
    return v[k*32 +: 32];
  endfunction

  // Reference arbitration rule: first requester at or after pointer, wrapping.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  // Snoop address vector: every core except the requester sees addr.
  function automatic logic [N*32-1:0] snoop_vec(input int r, input logic [31:0] a);
    logic [N*32-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) if (k != r) v[k*32 +: 32] = a;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = RS_FREE;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    nRST = 1'b0;
    iREN = '1; dWEN = '1; cctrans = '1; ccwrite = '1; ramstate = RS_ACCESS;
    @(negedge CLK); #1;
    checks++; if (iwait !== 4'hF) begin errors++; $display("FAIL rst_iwait: got %h expected f", iwait); end
    checks++; if (dwait !== 4'hF) begin errors++; $display("FAIL rst_dwait: got %h expected f", dwait); end
    checks++; if (ccwait !== 4'h0 || ccinv !== 4'h0) begin errors++; $display("FAIL rst_cc: got ccwait=%h ccinv=%h expected 0 0", ccwait, ccinv); end
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL rst_strobe: got ren=%b wen=%b expected 0 0", ramREN, ramWEN); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL rst_ramaddr: got %h/%h expected 0", ramaddr, ramstore); end
    checks++; if (iload !== '0 || dload !== '0 || ccsnoopaddr !== '0) begin errors++; $display("FAIL rst_data: got nonzero load/snoop expected 0"); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    checks++; if (perf_trans !== 32'd0 || perf_c2c !== 32'd0) begin errors++; $display("FAIL rst_perf: got %0d/%0d expected 0/0", perf_trans, perf_c2c); end
    clear_inputs();
  endtask

  task automatic test_ifetch_rr();
    logic [1:0] w;
    do_reset();
    iREN = 4'hF;
    for (int k = 0; k < N; k++) iaddr[k*32 +: 32] = $urandom;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      ramstate = (c % 2 == 1) ? RS_ACCESS : RS_BUSY;
      ramload  = $urandom;
      #1;
      w = exp_q[0];
      checks++; if (ramREN !== 1'b1 || ramaddr !== wd(iaddr, int'(w))) begin errors++; $display("FAIL if_addr: got ren=%b addr=%h expected 1 %h", ramREN, ramaddr, wd(iaddr, int'(w))); end
      if (ramstate == RS_ACCESS) begin
        checks++; if (iwait !== ~(4'b0001 << w)) begin errors++; $display("FAIL if_order: got iwait=%b expected %b", iwait, ~(4'b0001 << w)); end
        checks++; if (wd(iload, int'(w)) !== ramload) begin errors++; $display("FAIL if_load: got %h expected %h", wd(iload, int'(w)), ramload); end
        void'(exp_q.pop_front());
      end else begin
        checks++; if (iwait !== 4'hF) begin errors++; $display("FAIL if_stall: got iwait=%b expected 1111", iwait); end
      end
      @(negedge CLK);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL if_timeout: got %0d pending expected 0", exp_q.size()); end
    clear_inputs();
  endtask

  task automatic test_snoop_ram();
    logic [31:0] r;
    do_reset();
    daddr[2*32 +: 32] = 32'h100;
    cctrans = 4'b0100; dREN = 4'b0100; ramstate = RS_BUSY;
    #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ccwait !== 4'h0) begin errors++; $display("FAIL sr_idle: got ren=%b wen=%b ccwait=%b expected 0 0 0000", ramREN, ramWEN, ccwait); end
    @(negedge CLK); #1;
    checks++; if (ccwait !== 4'b1011) begin errors++; $display("FAIL sr_ccwait: got %b expected 1011", ccwait); end
    checks++; if (ccsnoopaddr !== snoop_vec(2, 32'h100)) begin errors++; $display("FAIL sr_snoopaddr: got %h expected %h", ccsnoopaddr, snoop_vec(2, 32'h100)); end
    checks++; if (ccinv !== 4'h0 || ramREN !== 1'b0) begin errors++; $display("FAIL sr_snoop_quiet: got ccinv=%b ren=%b expected 0000 0", ccinv, ramREN); end
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || dwait !== 4'hF) begin errors++; $display("FAIL sr_busy: got ren=%b addr=%h dwait=%b expected 1 100 1111", ramREN, ramaddr, dwait); end
    @(negedge CLK);
    r = $urandom; ramload = r; ramstate = RS_ACCESS;
    #1;
    checks++; if (dwait !== 4'b1011) begin errors++; $display("FAIL sr_dwait: got %b expected 1011", dwait); end
    checks++; if (wd(dload, 2) !== r) begin errors++; $display("FAIL sr_dload: got %h expected %h", wd(dload, 2), r); end
    @(negedge CLK);
    cctrans = '0; dREN = '0; ramstate = RS_FREE;
    @(negedge CLK); #1;
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL sr_exit: got state %0d expected 0", dbg_state); end
    clear_inputs();
  endtask

  task automatic test_c2c();
    logic [31:0] a;
    do_reset();
    a = $urandom;
    daddr[0 +: 32] = a; dstore[3*32 +: 32] = 32'hDEAD;
    cctrans = 4'b0001; dREN = 4'b0001; ccwrite = 4'b1001; ramstate = RS_BUSY;
    @(negedge CLK); #1;
    checks++; if (ccinv !== 4'b1110 || ccwait !== 4'b1110) begin errors++; $display("FAIL c2c_inv: got ccinv=%b ccwait=%b expected 1110 1110", ccinv, ccwait); end
    @(negedge CLK); #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== a || ramstore !== 32'hDEAD) begin errors++; $display("FAIL c2c_wb: got wen=%b ren=%b addr=%h store=%h expected 1 0 %h dead", ramWEN, ramREN, ramaddr, ramstore, a); end
    checks++; if (wd(dload, 0) !== 32'hDEAD || dwait !== 4'hF) begin errors++; $display("FAIL c2c_data: got dload0=%h dwait=%b expected dead 1111", wd(dload, 0), dwait); end
    @(negedge CLK);
    ramstate = RS_ACCESS;
    #1;
    checks++; if (dwait !== 4'b0110) begin errors++; $display("FAIL c2c_done: got dwait=%b expected 0110", dwait); end
    checks++; if (perf_c2c !== (PERF_ON ? 32'd1 : 32'd0) || perf_trans !== (PERF_ON ? 32'd1 : 32'd0)) begin errors++; $display("FAIL c2c_perf: got %0d/%0d", perf_c2c, perf_trans); end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_evict_priority();
    logic [31:0] a, d, b;
    do_reset();
    a = $urandom; d = $urandom; b = $urandom;
    daddr[1*32 +: 32] = a; dstore[1*32 +: 32] = d; dWEN = 4'b0010;
    iaddr[0 +: 32] = b; iREN = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      ramstate = (c == 2) ? RS_ACCESS : ((c == 0) ? RS_ERROR : RS_BUSY);
      #1;
      checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== a || ramstore !== d) begin errors++; $display("FAIL ev_write: got wen=%b ren=%b addr=%h store=%h expected 1 0 %h %h", ramWEN, ramREN, ramaddr, ramstore, a, d); end
      checks++; if (dwait !== ((c == 2) ? 4'b1101 : 4'b1111) || iwait !== 4'hF) begin errors++; $display("FAIL ev_wait: c=%0d got dwait=%b iwait=%b", c, dwait, iwait); end
      @(negedge CLK);
    end
    dWEN = '0; ramstate = RS_BUSY;
    #1;
    checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== b) begin errors++; $display("FAIL ev_then_if: got ren=%b wen=%b addr=%h expected 1 0 %h", ramREN, ramWEN, ramaddr, b); end
    @(negedge CLK);
    ramstate = RS_ACCESS; ramload = $urandom;
    #1;
    checks++; if (iwait !== 4'b1110 || wd(iload, 0) !== ramload) begin errors++; $display("FAIL ev_if_done: got iwait=%b iload0=%h expected 1110 %h", iwait, wd(iload, 0), ramload); end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_back_to_back_cc();
    logic [31:0] a1, a3;
    do_reset();
    dWEN = 4'b0010; ramstate = RS_ACCESS;  // eviction by core1 moves the data pointer to 2
    #1;
    checks++; if (dwait !== 4'b1101) begin errors++; $display("FAIL bb_evict: got %b expected 1101", dwait); end
    @(negedge CLK);
    a1 = $urandom; a3 = $urandom;
    dWEN = '0; cctrans = 4'b1010; dREN = 4'b1010; ramstate = RS_BUSY;
    daddr[1*32 +: 32] = a1; daddr[3*32 +: 32] = a3;
    #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL bb_idle: got ren=%b wen=%b expected 0 0", ramREN, ramWEN); end
    @(negedge CLK); #1;
    checks++; if (ccwait !== 4'b0111 || ccsnoopaddr !== snoop_vec(3, a3)) begin errors++; $display("FAIL bb_first: got ccwait=%b snoop=%h expected 0111 %h", ccwait, ccsnoopaddr, snoop_vec(3, a3)); end
    @(negedge CLK);
    ramstate = RS_ACCESS; ramload = $urandom;
    #1;
    checks++; if (dwait !== 4'b0111 || ramaddr !== a3 || wd(dload, 3) !== ramload) begin errors++; $display("FAIL bb_first_done: got dwait=%b addr=%h expected 0111 %h", dwait, ramaddr, a3); end
    @(negedge CLK);
    cctrans = 4'b0010; dREN = 4'b0010; ramstate = RS_BUSY;
    #1;
    checks++; if (dwait !== 4'hF) begin errors++; $display("FAIL bb_loser_wait: got %b expected 1111", dwait); end
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (ccwait !== 4'b1101 || ccsnoopaddr !== snoop_vec(1, a1)) begin errors++; $display("FAIL bb_second: got ccwait=%b snoop=%h expected 1101 %h", ccwait, ccsnoopaddr, snoop_vec(1, a1)); end
    @(negedge CLK);
    ramstate = RS_ACCESS;
    #1;
    checks++; if (dwait !== 4'b1101 || ramaddr !== a1) begin errors++; $display("FAIL bb_second_done: got dwait=%b addr=%h expected 1101 %h", dwait, ramaddr, a1); end
    checks++; if (perf_trans !== (PERF_ON ? 32'd2 : 32'd0)) begin errors++; $display("FAIL bb_perf_trans: got %0d expected %0d", perf_trans, PERF_ON ? 2 : 0); end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_reset_mid_c2c();
    do_reset();
    daddr[0 +: 32] = $urandom; dstore[3*32 +: 32] = $urandom;
    cctrans = 4'b0001; dREN = 4'b0001; ccwrite = 4'b1001; ramstate = RS_BUSY;
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (dbg_state !== 2'd2 || ramWEN !== 1'b1) begin errors++; $display("FAIL mr_in_c2c: got state=%0d wen=%b expected 2 1", dbg_state, ramWEN); end
    nRST = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'd0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL mr_async: got state=%0d wen=%b addr=%h", dbg_state, ramWEN, ramaddr); end
    @(posedge CLK); #1;
    checks++; if (iwait !== 4'hF || dwait !== 4'hF || ccwait !== 4'h0 || ccinv !== 4'h0 || dload !== '0 || ccsnoopaddr !== '0) begin errors++; $display("FAIL mr_outputs: got iwait=%b dwait=%b ccwait=%b ccinv=%b", iwait, dwait, ccwait, ccinv); end
    checks++; if (perf_trans !== 32'd0 || perf_c2c !== 32'd0 || dbg_state !== 2'd0) begin errors++; $display("FAIL mr_state: got perf=%0d/%0d state=%0d expected 0/0 0", perf_trans, perf_c2c, dbg_state); end
    clear_inputs();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_random_arb();
    bit ipend[N], epend[N];
    logic [31:0] ia[N], da[N], ds[N];
    logic [N-1:0] im, em;
    int dp, ip, w;
    bit acc;
    do_reset();
    dp = 0; ip = 0;
    for (int k = 0; k < N; k++) begin ipend[k] = 0; epend[k] = 0; end
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!ipend[k] && $urandom_range(0, 2) == 0) begin ipend[k] = 1; ia[k] = $urandom; end
        if (!epend[k] && $urandom_range(0, 4) == 0) begin epend[k] = 1; da[k] = $urandom; ds[k] = $urandom; end
        im[k] = ipend[k]; em[k] = epend[k];
        iaddr[k*32 +: 32] = ia[k]; daddr[k*32 +: 32] = da[k]; dstore[k*32 +: 32] = ds[k];
      end
      iREN = im; dWEN = em;
      ramstate = 2'($urandom_range(0, 3));
      ramload = $urandom;
      acc = (ramstate == RS_ACCESS);
      #1;
      if (|em) begin
        w = pick(em, dp);
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== da[w] || ramstore !== ds[w]) begin errors++; $display("FAIL rnd_evict c=%0d: got wen=%b addr=%h store=%h expected core %0d %h %h", c, ramWEN, ramaddr, ramstore, w, da[w], ds[w]); end
        checks++; if (dwait !== (acc ? ~(4'b0001 << w) : 4'hF) || iwait !== 4'hF) begin errors++; $display("FAIL rnd_evict_wait c=%0d: got dwait=%b iwait=%b core %0d", c, dwait, iwait, w); end
        if (acc) begin epend[w] = 0; dp = (w + 1) % N; end
      end else if (|im) begin
        w = pick(im, ip);
        checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== ia[w]) begin errors++; $display("FAIL rnd_if c=%0d: got ren=%b addr=%h expected core %0d %h", c, ramREN, ramaddr, w, ia[w]); end
        checks++; if (iwait !== (acc ? ~(4'b0001 << w) : 4'hF) || dwait !== 4'hF) begin errors++; $display("FAIL rnd_if_wait c=%0d: got iwait=%b dwait=%b core %0d", c, iwait, dwait, w); end
        if (acc) begin
          checks++; if (wd(iload, w) !== ramload) begin errors++; $display("FAIL rnd_iload c=%0d: got %h expected %h", c, wd(iload, w), ramload); end
          ipend[w] = 0; ip = (w + 1) % N;
        end
      end else begin
        checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL rnd_idle c=%0d: got ren=%b wen=%b addr=%h", c, ramREN, ramWEN, ramaddr); end
      end
      @(negedge CLK);
    end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    nRST = 1'b0;
    clear_inputs();
    test_reset();
    test_ifetch_rr();
    test_snoop_ram();
    test_c2c();
    test_evict_priority();
    test_back_to_back_cc();
    test_reset_mid_c2c();
    test_random_arb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
